// File: rtl/mig_seq_eval.sv
// Sequencer that evaluates a stored majority-inverter graph one node per clock,
// either for a single input vector or swept over all 16 vectors into a truth table.
module mig_seq_eval #(
    parameter int NODES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  logic [14:0] cfg_data,
    input  logic        start,
    input  logic        sweep,
    input  logic [3:0]  x,
    output logic        busy,
    output logic        done,
    output logic        y,
    output logic [15:0] tt
);

    // start is a one-cycle request taken only in IDLE (no ready, no queuing);
    // done is a one-cycle pulse on which y or tt has just become valid.
    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_DONE
    } state_t;

    localparam logic [3:0] NODES4 = 4'(NODES);

    state_t      state, state_nx;
    logic [14:0] node_cfg [NODES];
    logic [3:0]  num_nodes;
    logic        out_inv;
    logic [3:0]  out_sel;

    logic        pend_we;
    logic [3:0]  pend_addr;
    logic [14:0] pend_data;

    logic        mode_sweep;
    logic [3:0]  vec;
    logic [3:0]  k;
    logic [NODES-1:0] node_val;

    logic [3:0]  p_last;
    logic [14:0] cur_w;
    logic        op_a, op_b, op_c, maj_val, out_val, last_k;
    logic [NODES-1:0] node_fwd;

    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [14:0] wr_data;

    function automatic logic operand(input logic inv, input logic [3:0] sel,
                                     input logic [3:0] v, input logic [NODES-1:0] nv);
        logic o;
        o = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (sel == 4'(j + 1)) o = v[j];
        end
        for (int j = 0; j < NODES; j++) begin
            if (sel == 4'(j + 5)) o = nv[j];
        end
        return o ^ inv;
    endfunction

    always_comb begin
        if (num_nodes > NODES4)       p_last = NODES4 - 4'd1;
        else if (num_nodes == 4'd0)   p_last = 4'd0;
        else                          p_last = num_nodes - 4'd1;
    end

    always_comb begin
        cur_w = '0;
        for (int j = 0; j < NODES; j++) begin
            if (k == 4'(j)) cur_w = node_cfg[j];
        end
        op_a    = operand(cur_w[14], cur_w[13:10], vec, node_val);
        op_b    = operand(cur_w[9],  cur_w[8:5],   vec, node_val);
        op_c    = operand(cur_w[4],  cur_w[3:0],   vec, node_val);
        maj_val = (op_a & op_b) | (op_a & op_c) | (op_b & op_c);
        // The output tap must see the node being written in this same cycle.
        node_fwd = node_val;
        for (int j = 0; j < NODES; j++) begin
            if (k == 4'(j)) node_fwd[j] = maj_val;
        end
        out_val = operand(out_inv, out_sel, vec, node_fwd);
        last_k  = (k == p_last);
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_EVAL;
            S_EVAL:  if (last_k && (!mode_sweep || vec == 4'd15)) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_sweep <= 1'b0;
            vec        <= '0;
            k          <= '0;
            node_val   <= '0;
            y          <= 1'b0;
            tt         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_sweep <= sweep;
                        vec        <= sweep ? 4'd0 : x;
                        k          <= '0;
                        node_val   <= '0;
                    end
                end
                S_EVAL: begin
                    node_val <= node_fwd;
                    if (last_k) begin
                        if (mode_sweep) begin
                            tt[vec] <= out_val;
                            if (vec != 4'd15) begin
                                vec      <= vec + 4'd1;
                                k        <= '0;
                                node_val <= '0;
                            end
                        end else begin
                            y <= out_val;
                        end
                    end else begin
                        k <= k + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A write landing with start is held back so the run sees the old config.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (state == S_DONE && pend_we) begin
            wr_en   = 1'b1;
            wr_addr = pend_addr;
            wr_data = pend_data;
        end else if (state == S_IDLE && cfg_we && !start) begin
            wr_en   = 1'b1;
            wr_addr = cfg_addr;
            wr_data = cfg_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NODES; j++) node_cfg[j] <= '0;
            num_nodes <= '0;
            out_inv   <= 1'b0;
            out_sel   <= '0;
            pend_we   <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
        end else begin
            if (wr_en) begin
                for (int j = 0; j < NODES; j++) begin
                    if (wr_addr == 4'(j)) node_cfg[j] <= wr_data;
                end
                if (wr_addr == 4'd15) begin
                    num_nodes <= wr_data[14:11];
                    out_inv   <= wr_data[10];
                    out_sel   <= wr_data[9:6];
                end
            end
            if (state == S_IDLE && cfg_we && start) begin
                pend_we   <= 1'b1;
                pend_addr <= cfg_addr;
                pend_data <= cfg_data;
            end else if (state == S_DONE) begin
                pend_we <= 1'b0;
            end
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_mig_seq_eval.sv
// Bench for mig_seq_eval: vector table, directed corner sequences and random
// configurations checked against a small behavioural MIG model.
module tb_mig_seq_eval;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [14:0] cfg_data;
    logic        start;
    logic        sweep;
    logic [3:0]  x;
    logic        busy, done, y;
    logic [15:0] tt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_q[$];
    int          lat_q[$];

    logic [14:0] sh_nodes [8];
    logic [14:0] sh_ctrl;
    logic        last_y;
    logic [15:0] last_tt;

    typedef struct {
        logic [14:0] n0, n1, n2;
        logic [14:0] ctrl;
        logic        sw;
        logic [3:0]  xv;
        logic [15:0] expv;
        int          lat;
    } tv_t;

    tv_t tv [11];

    mig_seq_eval #(.NODES(8)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .start(start), .sweep(sweep), .x(x),
        .busy(busy), .done(done), .y(y), .tt(tt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [14:0] nw(input logic ia, input logic [3:0] sa, input logic ib,
                                       input logic [3:0] sb, input logic ic, input logic [3:0] sc);
        return {ia, sa, ib, sb, ic, sc};
    endfunction

    function automatic logic [14:0] cw(input logic [3:0] num, input logic inv, input logic [3:0] sel);
        return {num, inv, sel, 6'b0};
    endfunction

    function automatic logic mop(input logic [4:0] o, input logic [3:0] v, input logic [10:0] n);
        int s;
        logic r;
        s = int'(o[3:0]);
        r = 1'b0;
        if (s >= 1 && s <= 4) r = v[s-1];
        if (s >= 5 && (s - 5) < 8) r = n[s-5];
        return r ^ o[4];
    endfunction

    function automatic logic model_out(input logic [3:0] v);
        logic [10:0] n;
        logic a, b, c;
        int p;
        n = '0;
        p = int'(sh_ctrl[14:11]);
        if (p > 8) p = 8;
        if (p == 0) p = 1;
        for (int kk = 0; kk < p; kk++) begin
            a = mop(sh_nodes[kk][14:10], v, n);
            b = mop(sh_nodes[kk][9:5], v, n);
            c = mop(sh_nodes[kk][4:0], v, n);
            n[kk] = (a & b) | (b & c) | (a & c);
        end
        return mop({sh_ctrl[10], sh_ctrl[9:6]}, v, n);
    endfunction

    function automatic logic [15:0] model_tt();
        logic [15:0] t;
        for (int i = 0; i < 16; i++) t[i] = model_out(4'(i));
        return t;
    endfunction

    function automatic int model_p();
        int p;
        p = int'(sh_ctrl[14:11]);
        if (p > 8) p = 8;
        if (p == 0) p = 1;
        return p;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [14:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (a < 4'd8) sh_nodes[a] = d;
        else if (a == 4'd15) sh_ctrl = d;
    endtask

    // inj < 0: nothing; inj == 0: config write of inj_w to node0 alongside start;
    // inj > 0: start plus node0 write during busy cycle T0+inj.
    task automatic run_eval(input logic sw, input logic [3:0] xv, input logic [15:0] expv,
                            input int lat, input int inj, input logic [14:0] inj_w);
        int cyc;
        logic [15:0] e;
        int el;
        exp_q.push_back(expv);
        lat_q.push_back(lat);
        @(negedge clk);
        start = 1'b1; sweep = sw; x = xv;
        if (inj == 0) begin
            cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = inj_w;
        end
        @(posedge clk); #1;
        start = 1'b0; cfg_we = 1'b0;
        check("busy_after_start", {15'd0, busy}, 16'd1);
        cyc = 1;
        while (!done && cyc < 400) begin
            if (cyc == inj) begin
                start = 1'b1; sweep = 1'b1; x = 4'hF;
                cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = inj_w;
            end
            @(posedge clk); #1;
            start = 1'b0; cfg_we = 1'b0;
            cyc++;
        end
        e  = exp_q.pop_front();
        el = lat_q.pop_front();
        check("done_seen", {15'd0, done}, 16'd1);
        check("done_latency", 16'(cyc), 16'(el));
        if (sw) begin
            check("tt", tt, e);
            check("y_held", {15'd0, y}, {15'd0, last_y});
            last_tt = e;
        end else begin
            check("y", {15'd0, y}, {15'd0, e[0]});
            check("tt_held", tt, last_tt);
            last_y = e[0];
        end
        @(posedge clk); #1;
        check("done_pulse_end", {14'd0, done, busy}, 16'd0);
    endtask

    initial begin
        tv[0]  = '{nw(0,1,0,2,0,3), 15'd0, 15'd0, cw(1,0,5), 1'b1, 4'd0, 16'hE8E8, 17};
        tv[1]  = '{nw(0,1,0,2,0,3), 15'd0, 15'd0, cw(1,0,5), 1'b0, 4'd3, 16'h0001, 2};
        tv[2]  = '{nw(0,1,0,2,0,3), 15'd0, 15'd0, cw(1,0,5), 1'b0, 4'd4, 16'h0000, 2};
        tv[3]  = '{nw(0,1,0,2,0,0), nw(0,1,0,2,1,0), nw(0,6,1,5,0,0), cw(3,0,7), 1'b1, 4'd0, 16'h6666, 49};
        tv[4]  = '{nw(0,1,0,2,0,0), nw(0,1,0,2,1,0), nw(0,6,1,5,0,0), cw(3,1,7), 1'b1, 4'd0, 16'h9999, 49};
        tv[5]  = '{nw(0,1,0,2,0,0), nw(0,1,0,2,1,0), nw(0,6,1,5,0,0), cw(3,0,7), 1'b0, 4'd2, 16'h0001, 4};
        tv[6]  = '{nw(0,6,0,1,0,2), nw(1,0,1,0,1,0), 15'd0, cw(2,0,5), 1'b1, 4'd0, 16'h8888, 33};
        tv[7]  = '{nw(0,5,0,1,1,0), 15'd0, 15'd0, cw(1,0,5), 1'b1, 4'd0, 16'hAAAA, 17};
        tv[8]  = '{nw(0,3,0,3,0,0), 15'd0, 15'd0, cw(15,0,5), 1'b1, 4'd0, 16'hF0F0, 129};
        tv[9]  = '{nw(0,3,0,3,0,0), 15'd0, 15'd0, cw(1,1,15), 1'b1, 4'd0, 16'hFFFF, 17};
        tv[10] = '{nw(0,1,0,1,0,0), 15'd0, 15'd0, cw(0,0,5), 1'b1, 4'd0, 16'hAAAA, 17};

        for (int i = 0; i < 8; i++) sh_nodes[i] = '0;
        sh_ctrl = '0; last_y = 1'b0; last_tt = '0;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        start = 1'b0; sweep = 1'b0; x = '0;

        #22;
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_done", {15'd0, done}, 16'd0);
        check("rst_y", {15'd0, y}, 16'd0);
        check("rst_tt", tt, 16'd0);
        @(negedge clk); rst_n = 1'b1;

        run_eval(1'b1, 4'd0, 16'h0000, 17, -1, 15'd0);

        for (int i = 0; i < 11; i++) begin
            cfg_write(4'd0, tv[i].n0);
            cfg_write(4'd1, tv[i].n1);
            cfg_write(4'd2, tv[i].n2);
            cfg_write(4'd15, tv[i].ctrl);
            run_eval(tv[i].sw, tv[i].xv, tv[i].expv, tv[i].lat, -1, 15'd0);
        end

        // Busy protection: start and config write mid-sweep are both dropped.
        cfg_write(4'd0, nw(0,1,0,2,0,3));
        cfg_write(4'd15, cw(1,0,5));
        run_eval(1'b1, 4'd0, 16'hE8E8, 17, 5, nw(0,4,0,4,0,0));
        run_eval(1'b1, 4'd0, 16'hE8E8, 17, -1, 15'd0);
        cfg_write(4'd0, nw(0,4,0,4,0,0));
        run_eval(1'b1, 4'd0, 16'hFF00, 17, -1, 15'd0);

        // Write with start: run uses old config, new word applies afterwards.
        run_eval(1'b1, 4'd0, 16'hFF00, 17, 0, nw(0,1,0,2,0,3));
        sh_nodes[0] = nw(0,1,0,2,0,3);
        run_eval(1'b1, 4'd0, 16'hE8E8, 17, -1, 15'd0);
        run_eval(1'b0, 4'd7, 16'h0001, 2, -1, 15'd0);

        // Reset partway through a sweep.
        @(negedge clk); start = 1'b1; sweep = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) @(posedge clk);
        #1; rst_n = 1'b0;
        #1;
        check("midrst_busy", {15'd0, busy}, 16'd0);
        check("midrst_done", {15'd0, done}, 16'd0);
        check("midrst_y", {15'd0, y}, 16'd0);
        check("midrst_tt", tt, 16'd0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 8; i++) sh_nodes[i] = '0;
        sh_ctrl = '0; last_y = 1'b0; last_tt = '0;
        run_eval(1'b1, 4'd0, 16'h0000, 17, -1, 15'd0);
        cfg_write(4'd0, nw(0,1,0,2,0,3));
        cfg_write(4'd15, cw(1,0,5));
        run_eval(1'b1, 4'd0, 16'hE8E8, 17, -1, 15'd0);

        // Random netlists against the behavioural model.
        for (int r = 0; r < 8; r++) begin
            for (int j = 0; j < 8; j++) cfg_write(4'(j), 15'($urandom_range(0, 32767)));
            cfg_write(4'd15, cw(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                                4'($urandom_range(0, 15))));
            if (r % 3 == 2) begin
                logic [3:0] xr;
                xr = 4'($urandom_range(0, 15));
                run_eval(1'b0, xr, {15'd0, model_out(xr)}, model_p() + 1, -1, 15'd0);
            end else begin
                run_eval(1'b1, 4'd0, model_tt(), 16 * model_p() + 1, -1, 15'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mig_seq_eval.md
# mig_seq_eval

Programmable sequencer that evaluates a 4-input majority-inverter graph (MIG) netlist of up to NODES majority nodes, one node per clock, on one shared 3-input majority unit with per-operand inversion. It sits beside the exact-synthesis MIG netlists and executes any of them from a configuration store instead of hard-wired logic. It evaluates one input vector or sweeps all 16 vectors to produce the 16-bit truth table for equivalence checking against a golden function.

## Interface
- NODES, default 8: node-store depth; legal range 1..11.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  write strobe; ignored while busy=1.
- cfg_addr  in  4  0..NODES-1 = node word; 15 = control word; other values are ignored.
- cfg_data  in  15  node word {inv_a, sel_a[3:0], inv_b, sel_b[3:0], inv_c, sel_c[3:0]}; control word {num_nodes[3:0] in bits 14:11, out_inv in bit 10, out_sel[3:0] in bits 9:6}, bits 5:0 ignored.
- start  in  1  begin evaluation; accepted only in IDLE.
- sweep  in  1  sampled with start: 0 = single vector, 1 = all 16 vectors.
- x  in  4  input vector {x3,x2,x1,x0}; sampled with start in single mode.
- busy  out  1  high from the cycle after accepted start through the DONE cycle.
- done  out  1  one-cycle pulse; results valid.
- y  out  1  single-mode result; held until next accepted start.
- tt  out  16  sweep result, bit i = f(x=i); held until next accepted start.

## Operation
- Operand select: 0 = const 0; 1..4 = x0..x3; 5..15 = node 0..10. Selects for nodes at or above NODES read 0. The inv bit complements the operand, so const 1 = sel 0 with inv set.
- Node value: n[k] = MAJ(a,b,c) of the three post-inversion operands.
- The output applies out_sel and out_inv the same way. With sel 5+k it returns n[k].
- num_nodes is clamped to NODES. Per-vector cost P = max(num_nodes,1) cycles.
- Node register file is cleared to 0 at the start of every vector. A forward reference (node j >= k read by node k) therefore reads 0. Self-reference also reads 0.
- FSM states:
  - IDLE: start moves to EVAL. Latch the mode, set vec = x (single) or vec = 0 (sweep), set k = 0, clear the node regs.
  - EVAL: each cycle write n[k]. If k = P-1, evaluate the output for this vec. In single mode, store it to y and go to DONE. In sweep mode, store it to tt[vec]; if vec = 15 go to DONE, else vec+1, k = 0, clear the node regs.
  - DONE: done = 1 for one cycle, then IDLE.
- Results: y and tt are updated only at completion and are not cleared by a new start until overwritten. In single mode tt holds its old value; in sweep mode y holds its old value.
- Config writes are accepted in IDLE only, including the cycle of start. A same-cycle write and start evaluates the old config.
- Reset: asynchronous, valid mid-operation.
  - State goes to IDLE; busy = 0, done = 0, y = 0, tt = 0.
  - All node words, num_nodes, out_sel and out_inv are cleared to 0, so the default function is const 0.

## Timing
- Start sampled at edge T0. busy = 1 from T0+1.
- Single mode: y valid and done = 1 in cycle T0+P+1; busy drops at T0+P+2.
- Sweep mode: done at T0+16P+1.
- start while busy is ignored, with no queuing. Start in the DONE cycle is also ignored.
- MAJ evaluation and operand muxing are combinational within one cycle. The node regfile is read and written in the same cycle; a node reads the values of lower-indexed nodes written in earlier cycles.

## Test plan
- Reset defaults: hold rst_n low → busy=0, done=0, y=0, tt=0. Then sweep with no config → done after 17 cycles (P=1), tt=0x0000.
- Majority:
  - Config: node0 = {0,1,0,2,0,3}; control num_nodes=1, out_sel=5, out_inv=0.
  - Sweep → tt=0xE8E8, done at T0+17.
  - Single x=4'b0011 → y=1 at T0+2.
- XOR over 3 nodes:
  - Config: n0=M(x0,x1,0); n1=M(x0,x1,~0); n2=M(n1,~n0,0); num_nodes=3, out_sel=7.
  - Sweep → tt=0x6666, done at T0+49.
  - Same config with out_inv=1 → tt=0x9999.
- Forward reference: node0 reads node1, num_nodes=2, out_sel=5 → node0 reads 0. Verify tt against that model.
- Busy protection: during a sweep, pulse start with cfg_we writing new node0 → both ignored; tt matches the old config; the new config takes effect only when rewritten in IDLE.
- Reset mid-sweep: assert rst_n low at T0+10 → busy, done, y and tt go to 0 immediately. The next sweep after reprogramming completes normally.
